// File: rtl/main_fsm.sv
// Multicycle RV32I main controller: Moore FSM over fetch/decode/execute/memory/writeback; R/I 4, lw 5, sw 4, beq 3, jal 4, jalr 5 cycles.
// FETCH/MEMREAD/MEMWRITE hold while MemReady=0 (when MEM_HANDSHAKE=1); lui/auipc decode only with MAIN_FSM_UTYPE_EN.
module main_fsm #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [6:0]         op,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [2:0]         ImmSrc,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UTYPE    = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t state, state_n;
    logic   ready;
    logic   pcupdate, branch;
    logic   irwrite_i, regwrite_i, memwrite_i, illegal_i;

    assign ready = MemReady || (MEM_HANDSHAKE == 0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_n;
    end

    always_comb begin
        state_n    = state;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        irwrite_i  = 1'b0;
        regwrite_i = 1'b0;
        memwrite_i = 1'b0;
        illegal_i  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irwrite_i = ready;
                pcupdate  = ready;
                if (ready) state_n = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_RTYPE:          state_n = S_EXECR;
                    OP_ITYPE:          state_n = S_EXECI;
                    OP_BRANCH:         state_n = S_BEQ;
                    OP_JAL:            state_n = S_JAL;
                    OP_JALR:           state_n = S_JALR;
`ifdef MAIN_FSM_UTYPE_EN
                    OP_LUI, OP_AUIPC:  state_n = S_UTYPE;
`endif
                    default:           state_n = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_n = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (ready) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                regwrite_i = 1'b1;
                state_n    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                memwrite_i = 1'b1;
                if (ready) state_n = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_n = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_i = 1'b1;
                state_n    = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
                state_n = S_FETCH;
            end
            // rs1+imm lands in ALUOut, then JAL loads it into PC and links OldPC+4
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_n = S_JAL;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcupdate = 1'b1;
                state_n  = S_ALUWB;
            end
`ifdef MAIN_FSM_UTYPE_EN
            S_UTYPE: begin
                ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01;
                ALUSrcB = 2'b01;
                state_n = S_ALUWB;
            end
`endif
            S_TRAP: begin
                illegal_i = 1'b1;
            end
            default: state_n = S_TRAP;
        endcase
    end

    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_STORE:        ImmSrc = 3'b001;
            OP_BRANCH:       ImmSrc = 3'b010;
            OP_JAL:          ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:         ImmSrc = 3'b000;
        endcase
    end

    // Enables are gated by reset_n so nothing writes while reset is held
    assign PCWrite  = reset_n & (pcupdate | (branch & Zero));
    assign IRWrite  = reset_n & irwrite_i;
    assign RegWrite = reset_n & regwrite_i;
    assign MemWrite = reset_n & memwrite_i;
    assign Illegal  = reset_n & illegal_i;
    assign State    = STATE_W'(state);

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: walks each instruction class through its state sequence.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;

    main_fsm #(.MEM_HANDSHAKE(1), .STATE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        MemReady = 1'b1;
        Zero     = 1'b1;
        op       = 7'b0000011;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (State !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", State); end
        checks++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite, Illegal} !== 5'b0) begin
            errors++; $display("FAIL reset_enables: got %b expected 00000", {PCWrite, IRWrite, RegWrite, MemWrite, Illegal});
        end
        checks++;
        if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== 7'b0_00_10_10) begin
            errors++; $display("FAIL reset_fetch_mux: got %b expected 0001010", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc});
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if ({PCWrite, IRWrite} !== 2'b11) begin errors++; $display("FAIL release_fetch_en: got %b expected 11", {PCWrite, IRWrite}); end
    endtask

    task automatic test_lw;
        logic [3:0] exp_st [5];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        op = 7'b0000011; MemReady = 1'b1; Zero = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (State !== exp_st[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, State, exp_st[i]); end
            checks++;
            if (RegWrite !== (i == 4)) begin errors++; $display("FAIL lw_regwrite[%0d]: got %b expected %b", i, RegWrite, (i == 4)); end
            if (i == 1) begin
                checks++;
                if ({ALUSrcA, ALUSrcB} !== 4'b0101) begin errors++; $display("FAIL decode_mux: got %b expected 0101", {ALUSrcA, ALUSrcB}); end
            end
            if (i == 4) begin
                checks++;
                if (ResultSrc !== 2'b01) begin errors++; $display("FAIL lw_resultsrc: got %b expected 01", ResultSrc); end
            end
            tick();
        end
        checks++;
        if (State !== 4'd0) begin errors++; $display("FAIL lw_return: got %0d expected 0", State); end
    endtask

    task automatic test_sw_wait;
        op = 7'b0100011; MemReady = 1'b1;
        #1;
        tick();
        checks++;
        if (ImmSrc !== 3'b001) begin errors++; $display("FAIL sw_immsrc: got %b expected 001", ImmSrc); end
        tick();
        checks++;
        if (State !== 4'd2) begin errors++; $display("FAIL sw_memadr: got %0d expected 2", State); end
        tick();
        MemReady = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin MemReady = 1'b1; #1; end
            checks++;
            if ({State, MemWrite, AdrSrc} !== {4'd5, 2'b11}) begin
                errors++; $display("FAIL sw_hold[%0d]: got state %0d mw %b adr %b expected 5 1 1", i, State, MemWrite, AdrSrc);
            end
            tick();
        end
        checks++;
        if ({State, MemWrite} !== {4'd0, 1'b0}) begin errors++; $display("FAIL sw_done: got state %0d mw %b expected 0 0", State, MemWrite); end
    endtask

    task automatic test_beq;
        for (int z = 1; z >= 0; z--) begin
            op = 7'b1100011; Zero = z[0]; MemReady = 1'b1;
            #1;
            tick();
            checks++;
            if ({State, ImmSrc} !== {4'd1, 3'b010}) begin errors++; $display("FAIL beq_decode: got %0d/%b expected 1/010", State, ImmSrc); end
            tick();
            checks++;
            if ({State, PCWrite, ALUOp} !== {4'd9, z[0], 2'b01}) begin
                errors++; $display("FAIL beq_z%0d: got state %0d pcw %b aluop %b expected 9 %b 01", z, State, PCWrite, ALUOp, z[0]);
            end
            tick();
            checks++;
            if (State !== 4'd0) begin errors++; $display("FAIL beq_return: got %0d expected 0", State); end
        end
    endtask

    task automatic test_jalr;
        logic [3:0] exp_st [6];
        exp_st = '{4'd0, 4'd1, 4'd11, 4'd10, 4'd8, 4'd0};
        op = 7'b1100111; Zero = 1'b0; MemReady = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (State !== exp_st[i]) begin errors++; $display("FAIL jalr_state[%0d]: got %0d expected %0d", i, State, exp_st[i]); end
            if (i >= 2 && i <= 4) begin
                checks++;
                if ({PCWrite, RegWrite} !== {(i == 3), (i == 4)}) begin
                    errors++; $display("FAIL jalr_en[%0d]: got %b expected %b", i, {PCWrite, RegWrite}, {(i == 3), (i == 4)});
                end
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_fetch_wait_rtype;
        op = 7'b0110011; MemReady = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({State, IRWrite, PCWrite} !== {4'd0, 2'b00}) begin
                errors++; $display("FAIL fetch_wait[%0d]: got state %0d ir %b pc %b expected 0 0 0", i, State, IRWrite, PCWrite);
            end
            tick();
        end
        MemReady = 1'b1;
        #1;
        checks++;
        if (IRWrite !== 1'b1) begin errors++; $display("FAIL fetch_go: got %b expected 1", IRWrite); end
        tick();
        tick();
        checks++;
        if ({State, ALUSrcA, ALUSrcB, ALUOp} !== {4'd6, 6'b10_00_10}) begin
            errors++; $display("FAIL execr: got %0d %b expected 6 100010", State, {ALUSrcA, ALUSrcB, ALUOp});
        end
        tick();
        checks++;
        if ({State, RegWrite, ResultSrc} !== {4'd8, 3'b1_00}) begin
            errors++; $display("FAIL aluwb: got %0d %b expected 8 100", State, {RegWrite, ResultSrc});
        end
        tick();
        checks++;
        if (State !== 4'd0) begin errors++; $display("FAIL rtype_return: got %0d expected 0", State); end
    endtask

    task automatic test_reset_mid;
        op = 7'b0000011; MemReady = 1'b1;
        #1;
        tick();
        tick();
        MemReady = 1'b0;
        tick();
        checks++;
        if ({State, AdrSrc} !== {4'd3, 1'b1}) begin errors++; $display("FAIL memread_hold: got %0d %b expected 3 1", State, AdrSrc); end
        MemReady = 1'b1;
        reset_n  = 1'b0;
        #1;
        checks++;
        if ({State, PCWrite, IRWrite, RegWrite, MemWrite} !== {4'd0, 4'b0}) begin
            errors++; $display("FAIL mid_reset: got %0d %b expected 0 0000", State, {PCWrite, IRWrite, RegWrite, MemWrite});
        end
        tick();
        checks++;
        if ({State, PCWrite, IRWrite, RegWrite} !== {4'd0, 3'b0}) begin
            errors++; $display("FAIL mid_reset_held: got %0d %b expected 0 000", State, {PCWrite, IRWrite, RegWrite});
        end
        reset_n = 1'b1;
        #1;
        tick();
        checks++;
        if (State !== 4'd1) begin errors++; $display("FAIL post_reset_fetch: got %0d expected 1", State); end
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (State !== 4'd0) begin errors++; $display("FAIL post_reset_lw_done: got %0d expected 0", State); end
    endtask

    task automatic test_utype;
        op = 7'b0110111; MemReady = 1'b1;
        #1;
        tick();
        checks++;
        if ({State, ImmSrc} !== {4'd1, 3'b100}) begin errors++; $display("FAIL lui_decode: got %0d %b expected 1 100", State, ImmSrc); end
        tick();
`ifdef MAIN_FSM_UTYPE_EN
        checks++;
        if ({State, ALUSrcA, ALUSrcB, ALUOp} !== {4'd12, 6'b11_01_00}) begin
            errors++; $display("FAIL lui_utype: got %0d %b expected 12 110100", State, {ALUSrcA, ALUSrcB, ALUOp});
        end
        tick();
        checks++;
        if ({State, RegWrite} !== {4'd8, 1'b1}) begin errors++; $display("FAIL lui_wb: got %0d %b expected 8 1", State, RegWrite); end
        tick();
`else
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({State, Illegal, PCWrite, IRWrite, RegWrite, MemWrite} !== {4'd15, 5'b10000}) begin
                errors++; $display("FAIL lui_trap[%0d]: got %0d %b expected 15 10000", i, State,
                                   {Illegal, PCWrite, IRWrite, RegWrite, MemWrite});
            end
            tick();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({State, Illegal} !== {4'd0, 1'b0}) begin errors++; $display("FAIL trap_clear: got %0d %b expected 0 0", State, Illegal); end
        reset_n = 1'b1;
        #1;
`endif
        checks++;
        if (State !== 4'd0) begin errors++; $display("FAIL utype_end: got %0d expected 0", State); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_jalr();
        test_fetch_wait_rtype();
        test_reset_mid();
        test_utype();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
